jtag_ir_unit: RTL and testbench
===============================

# jtag_ir_unit

Parametrised JTAG instruction register for the debug TAP. It captures, shifts and updates an IR of configurable length, driven by per-cycle strobes from the TAP controller. Compared with a plain IR it checks the shift length, substitutes BYPASS for unsupported opcodes, and reports sticky status through the capture pattern. It sits between the TAP controller and the DR mux and instruction decoder; `ir_out` selects the active data register.

## Interface
Parameters:
- `IR_WIDTH`, 5: instruction length in bits. Legal range 4..8.
- `DEFAULT_IR`, 5'h01: instruction loaded on any reset (IDCODE).
- `BYPASS_IR`, all ones: opcode substituted for unsupported instructions.
- `VALID_MASK`, 2**IR_WIDTH bits: bit n set means opcode n is supported. Default: bits 0x01, 0x10, 0x11 and 0x1F set.
- `STRICT_LEN`, 1: when 1, an update after a wrong-length shift is discarded; when 0, it is applied but flagged.

Ports:
- `clk`  in  1  TCK-domain clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `tap_reset`  in  1  synchronous reset strobe (Test-Logic-Reset).
- `tdi`  in  1  serial data in.
- `tdo`  out  1  serial data out; combinational, equal to `shift_reg[0]`.
- `capture_ir`, `shift_ir`, `update_ir`  in  1 each  TAP state strobes.
- `capture_status`  in  IR_WIDTH-3  external status, loaded into the top capture bits.
- `ir_out`  out  IR_WIDTH  active instruction.
- `ir_new`  out  1  one-cycle pulse when `ir_out` is (re)written by an update.
- `ir_subst`  out  1  level; high while `ir_out` holds a BYPASS substituted for an unsupported opcode.
- `len_err`  out  1  sticky; set when an update follows a shift of the wrong length.

## Operation
- State:
  - `shift_reg[IR_WIDTH-1:0]`
  - `ir_latch` (drives `ir_out`)
  - `shift_cnt`: saturates at IR_WIDTH+1, width $clog2(IR_WIDTH+2)
  - `ir_subst` register
  - `len_err` register
- Reset:
  - Either `rst_n`=0 (async) or `tap_reset`=1 (sync) sets `shift_reg` = `ir_latch` = DEFAULT_IR.
  - Also clears `shift_cnt`, `ir_new`, `ir_subst` and `len_err`.
  - Hence after reset `tdo` = DEFAULT_IR[0].
- Priority each cycle: `tap_reset` > `capture_ir` > `shift_ir` > `update_ir`. Only the highest asserted strobe acts.
- Capture:
  - `shift_reg` <= {capture_status, len_err, 1'b0, 1'b1}; the two LSBs are 2'b01 per IEEE 1149.1.
  - `shift_cnt` <= 0.
- Shift:
  - `shift_reg` <= {tdi, shift_reg[IR_WIDTH-1:1]}.
  - `shift_cnt` <= min(shift_cnt+1, IR_WIDTH+1).
- Update, classified by `shift_cnt`:
  - `shift_cnt` == 0 (Capture→Exit1→Update with no shifts): no-op. Latch, flags and `ir_new` are unchanged.
  - `shift_cnt` == IR_WIDTH: good update. If VALID_MASK[shift_reg] is set, `ir_latch` <= shift_reg and `ir_subst` <= 0. Otherwise `ir_latch` <= BYPASS_IR and `ir_subst` <= 1. `ir_new` pulses.
  - Any other nonzero `shift_cnt`: `len_err` <= 1. If STRICT_LEN=1, the latch is unchanged and there is no `ir_new`. If STRICT_LEN=0, the update proceeds as a good update.
  - After any update, `shift_cnt` <= 0, so a repeated update without a new capture is a no-op.
- `len_err` clears only on a reset. Its value is visible to the debugger at capture as bit 2.
- `ir_out` is never driven from `shift_reg` directly; it changes only at an update or a reset.

## Timing
- `tdo` changes combinationally from `shift_reg`. It presents bit 0 right after the capture edge and each subsequent shifted bit after every shift edge.
- Update latency: `ir_out`, `ir_subst` and `len_err` take their new values at the rising edge where `update_ir` is sampled high.
- `ir_new` is registered: high for exactly the one cycle following that edge, low otherwise.
- Asserting `rst_n` mid-shift immediately forces the reset values. Releasing it takes effect on the next edge. A partial shift is discarded.
- `tap_reset` concurrent with any strobe: reset wins and no `ir_new` is produced.
- `shift_cnt` saturates. Shifting IR_WIDTH+k bits for any k≥1 is treated as "long" and never wraps back to IR_WIDTH.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → `ir_out`=5'h01, `tdo`=1, `ir_new`=0, `len_err`=0 immediately, with no clock required.
- Capture/shift: `capture_status`=2'b10, capture, then 5 shifts of 5'h11 LSB-first → `tdo` sequence 1,0,0,0,1. Update → `ir_out`=5'h11 and `ir_new` high for exactly one cycle.
- Unsupported opcode: shift 5'h07 and update → `ir_out`=5'h1F, `ir_subst`=1. Next, a valid 5'h10 → `ir_subst`=0.
- Length error: shift 3 bits then update with STRICT_LEN=1 → `ir_out` unchanged, `len_err`=1, no `ir_new`. The next capture shows `tdo` bits 1,0,1 (bit 2 = `len_err`). Repeat with STRICT_LEN=0 → `ir_out` updated and `len_err`=1. Also shift 7 bits (long) with STRICT_LEN=1 → rejected.
- Edge cases:
  - Capture then update with zero shifts → no change, no flag.
  - A second update without a new capture → no-op.
  - `tap_reset` held with `update_ir` → `ir_out`=5'h01 and `len_err` cleared.
- Parametrisation: IR_WIDTH=8, DEFAULT_IR=8'h01, all-ones VALID_MASK → 8-bit round trip of 8'hA5. 7 shifts followed by an update set `len_err`.

Source files
------------

// File: rtl/jtag_ir_unit.sv
// ---------------------------------------------------------------------------
// jtag_ir_unit
//
// JTAG instruction register for the debug TAP. It captures, shifts and
// updates an IR of IR_WIDTH bits using per-cycle strobes from the TAP
// controller. The unit counts the bits shifted since the last capture and
// flags a sticky length error when an update follows a shift of the wrong
// length. Unsupported opcodes are replaced by BYPASS. The capture pattern
// carries external status plus the length-error flag, so the debugger can
// read both.
//
// Ports
//   clk            in   TCK-domain clock; all state changes on rising edge
//   rst_n          in   asynchronous active-low reset
//   tap_reset      in   synchronous reset strobe (Test-Logic-Reset)
//   tdi            in   serial data in
//   tdo            out  serial data out, combinational from shift register LSB
//   capture_ir     in   Capture-IR strobe
//   shift_ir       in   Shift-IR strobe
//   update_ir      in   Update-IR strobe
//   capture_status in   [IR_WIDTH-3] status loaded into the top capture bits
//   ir_out         out  [IR_WIDTH] active instruction
//   ir_new         out  one-cycle pulse after ir_out is written by an update
//   ir_subst       out  high while ir_out holds a substituted BYPASS
//   len_err        out  sticky wrong-length-update flag
// ---------------------------------------------------------------------------
module jtag_ir_unit #(
    parameter int                         IR_WIDTH   = 5,
    parameter logic [IR_WIDTH-1:0]        DEFAULT_IR = 'h01,
    parameter logic [IR_WIDTH-1:0]        BYPASS_IR  = '1,
    parameter logic [2**IR_WIDTH-1:0]     VALID_MASK = 'h8003_0002,
    parameter bit                         STRICT_LEN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tap_reset,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic                  capture_ir,
    input  logic                  shift_ir,
    input  logic                  update_ir,
    input  logic [IR_WIDTH-4:0]   capture_status,
    output logic [IR_WIDTH-1:0]   ir_out,
    output logic                  ir_new,
    output logic                  ir_subst,
    output logic                  len_err
);

    localparam int                CNT_W    = $clog2(IR_WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(IR_WIDTH);
    // One past a full shift; anything longer stays here so it never wraps
    // back to a "correct" length.
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(IR_WIDTH + 1);

    logic [IR_WIDTH-1:0] shift_q, shift_d;
    logic [IR_WIDTH-1:0] ir_q,    ir_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                new_q,   new_d;
    logic                subst_q, subst_d;
    logic                lerr_q,  lerr_d;

    logic                len_ok;
    assign len_ok = (cnt_q == CNT_FULL);

    always_comb begin
        shift_d = shift_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        new_d   = 1'b0;
        subst_d = subst_q;
        lerr_d  = lerr_q;

        // Strobe priority: tap_reset > capture > shift > update.
        if (tap_reset) begin
            shift_d = DEFAULT_IR;
            ir_d    = DEFAULT_IR;
            cnt_d   = '0;
            subst_d = 1'b0;
            lerr_d  = 1'b0;
        end else if (capture_ir) begin
            // Two LSBs fixed at 2'b01 as IEEE 1149.1 requires.
            shift_d = {capture_status, lerr_q, 2'b01};
            cnt_d   = '0;
        end else if (shift_ir) begin
            shift_d = {tdi, shift_q[IR_WIDTH-1:1]};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (update_ir && (cnt_q != '0)) begin
            // A zero count (no shift since capture, or a repeated update)
            // leaves everything untouched.
            cnt_d = '0;
            if (!len_ok) begin
                lerr_d = 1'b1;
            end
            if (len_ok || !STRICT_LEN) begin
                new_d = 1'b1;
                if (VALID_MASK[shift_q]) begin
                    ir_d    = shift_q;
                    subst_d = 1'b0;
                end else begin
                    ir_d    = BYPASS_IR;
                    subst_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= DEFAULT_IR;
            ir_q    <= DEFAULT_IR;
            cnt_q   <= '0;
            new_q   <= 1'b0;
            subst_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            new_q   <= new_d;
            subst_q <= subst_d;
            lerr_q  <= lerr_d;
        end
    end

    assign tdo      = shift_q[0];
    assign ir_out   = ir_q;
    assign ir_new   = new_q;
    assign ir_subst = subst_q;
    assign len_err  = lerr_q;

endmodule

// File: tb/tb_jtag_ir_unit.sv
module tb_jtag_ir_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared stimulus for the strict (s_) and lenient (l_) 5-bit instances.
    logic       rst_n = 1'b1;
    logic       tap_reset = 1'b0, tdi = 1'b0;
    logic       capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
    logic [1:0] capture_status = 2'b10;

    logic       s_tdo, s_new, s_sub, s_len;
    logic [4:0] s_ir;
    logic       l_tdo, l_new, l_sub, l_len;
    logic [4:0] l_ir;

    // 8-bit instance stimulus.
    logic       trst8 = 1'b0, tdi8 = 1'b0, cap8 = 1'b0, sh8 = 1'b0, upd8 = 1'b0;
    logic [4:0] cs8 = 5'b10110;
    logic       tdo8, new8, sub8, len8;
    logic [7:0] ir8;

    jtag_ir_unit #(.STRICT_LEN(1'b1)) u_strict (
        .clk(clk), .rst_n(rst_n), .tap_reset(tap_reset), .tdi(tdi), .tdo(s_tdo),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_status(capture_status), .ir_out(s_ir), .ir_new(s_new),
        .ir_subst(s_sub), .len_err(s_len)
    );

    jtag_ir_unit #(.STRICT_LEN(1'b0)) u_lax (
        .clk(clk), .rst_n(rst_n), .tap_reset(tap_reset), .tdi(tdi), .tdo(l_tdo),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_status(capture_status), .ir_out(l_ir), .ir_new(l_new),
        .ir_subst(l_sub), .len_err(l_len)
    );

    jtag_ir_unit #(.IR_WIDTH(8), .DEFAULT_IR(8'h01), .VALID_MASK('1), .STRICT_LEN(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .tap_reset(trst8), .tdi(tdi8), .tdo(tdo8),
        .capture_ir(cap8), .shift_ir(sh8), .update_ir(upd8),
        .capture_status(cs8), .ir_out(ir8), .ir_new(new8),
        .ir_subst(sub8), .len_err(len8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit       cap, sh, upd, trst, d;
        bit [4:0] ir;
        bit       tdo, nw, sub, len;
        bit [4:0] lir;
        bit       lnw, lsub, llen;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit cap, bit sh, bit upd, bit trst, bit d,
                                bit [4:0] ir, bit t, bit nw, bit sub, bit len,
                                bit [4:0] lir, bit lnw, bit lsub, bit llen);
        vec_t v;
        v.cap = cap; v.sh = sh; v.upd = upd; v.trst = trst; v.d = d;
        v.ir = ir; v.tdo = t; v.nw = nw; v.sub = sub; v.len = len;
        v.lir = lir; v.lnw = lnw; v.lsub = lsub; v.llen = llen;
        tbl.push_back(v);
    endfunction

    // Both instances expected to agree.
    function automatic void addb(bit cap, bit sh, bit upd, bit trst, bit d,
                                 bit [4:0] ir, bit t, bit nw, bit sub, bit len);
        add(cap, sh, upd, trst, d, ir, t, nw, sub, len, ir, nw, sub, len);
    endfunction

    task automatic step(input bit cap, input bit sh, input bit upd, input bit trst, input bit d);
        capture_ir = cap; shift_ir = sh; update_ir = upd; tap_reset = trst; tdi = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input bit cap, input bit sh, input bit upd, input bit d);
        cap8 = cap; sh8 = sh; upd8 = upd; tdi8 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;

        // Capture 10001, shift in 5'h11 (LSB first), update.
        addb(1,0,0,0,0, 5'h01,1,0,0,0);
        addb(0,1,0,0,1, 5'h01,0,0,0,0);
        addb(0,1,0,0,0, 5'h01,0,0,0,0);
        addb(0,1,0,0,0, 5'h01,0,0,0,0);
        addb(0,1,0,0,0, 5'h01,1,0,0,0);
        addb(0,1,0,0,1, 5'h01,1,0,0,0);
        addb(0,0,1,0,0, 5'h11,1,1,0,0);
        addb(0,0,0,0,0, 5'h11,1,0,0,0);
        // Repeated update without capture: no-op.
        addb(0,0,1,0,0, 5'h11,1,0,0,0);
        // Unsupported 5'h07 -> BYPASS.
        addb(1,0,0,0,0, 5'h11,1,0,0,0);
        addb(0,1,0,0,1, 5'h11,0,0,0,0);
        addb(0,1,0,0,1, 5'h11,0,0,0,0);
        addb(0,1,0,0,1, 5'h11,0,0,0,0);
        addb(0,1,0,0,0, 5'h11,1,0,0,0);
        addb(0,1,0,0,0, 5'h11,1,0,0,0);
        addb(0,0,1,0,0, 5'h1F,1,1,1,0);
        // Valid 5'h10 clears substitution.
        addb(1,0,0,0,0, 5'h1F,1,0,1,0);
        addb(0,1,0,0,0, 5'h1F,0,0,1,0);
        addb(0,1,0,0,0, 5'h1F,0,0,1,0);
        addb(0,1,0,0,0, 5'h1F,0,0,1,0);
        addb(0,1,0,0,0, 5'h1F,1,0,1,0);
        addb(0,1,0,0,1, 5'h1F,0,0,1,0);
        addb(0,0,1,0,0, 5'h10,0,1,0,0);
        // Capture then update with no shifts.
        addb(1,0,0,0,0, 5'h10,1,0,0,0);
        addb(0,0,1,0,0, 5'h10,1,0,0,0);
        // Short shift (3 bits): strict rejects, lenient applies 5'h1E -> BYPASS.
        addb(1,0,0,0,0, 5'h10,1,0,0,0);
        addb(0,1,0,0,1, 5'h10,0,0,0,0);
        addb(0,1,0,0,1, 5'h10,0,0,0,0);
        addb(0,1,0,0,1, 5'h10,0,0,0,0);
        add (0,0,1,0,0, 5'h10,0,0,0,1, 5'h1F,1,1,1);
        // Capture shows len_err in bit 2: tdo 1,0,1.
        add (1,0,0,0,0, 5'h10,1,0,0,1, 5'h1F,0,1,1);
        add (0,1,0,0,0, 5'h10,0,0,0,1, 5'h1F,0,1,1);
        add (0,1,0,0,0, 5'h10,1,0,0,1, 5'h1F,0,1,1);
        // Continue to 7 shifts total (long), then update.
        add (0,1,0,0,0, 5'h10,0,0,0,1, 5'h1F,0,1,1);
        add (0,1,0,0,0, 5'h10,1,0,0,1, 5'h1F,0,1,1);
        add (0,1,0,0,0, 5'h10,0,0,0,1, 5'h1F,0,1,1);
        add (0,1,0,0,0, 5'h10,0,0,0,1, 5'h1F,0,1,1);
        add (0,1,0,0,0, 5'h10,0,0,0,1, 5'h1F,0,1,1);
        add (0,0,1,0,0, 5'h10,0,0,0,1, 5'h1F,1,1,1);
        // tap_reset with update: reset wins, no ir_new.
        addb(0,0,1,1,0, 5'h01,1,0,0,0);
        addb(0,0,0,0,0, 5'h01,1,0,0,0);

        // Asynchronous reset with no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ir",    s_ir,  5'h01);
        chk("rst_tdo",   s_tdo, 1'b1);
        chk("rst_new",   s_new, 1'b0);
        chk("rst_len",   s_len, 1'b0);
        chk("rst_sub",   s_sub, 1'b0);
        chk("rst_ir8",   ir8,   8'h01);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].cap, tbl[i].sh, tbl[i].upd, tbl[i].trst, tbl[i].d);
            chk($sformatf("row%0d_s_ir", i),  s_ir,  tbl[i].ir);
            chk($sformatf("row%0d_s_tdo", i), s_tdo, tbl[i].tdo);
            chk($sformatf("row%0d_s_new", i), s_new, tbl[i].nw);
            chk($sformatf("row%0d_s_sub", i), s_sub, tbl[i].sub);
            chk($sformatf("row%0d_s_len", i), s_len, tbl[i].len);
            chk($sformatf("row%0d_l_ir", i),  l_ir,  tbl[i].lir);
            chk($sformatf("row%0d_l_new", i), l_new, tbl[i].lnw);
            chk($sformatf("row%0d_l_sub", i), l_sub, tbl[i].lsub);
            chk($sformatf("row%0d_l_len", i), l_len, tbl[i].llen);
        end

        // Async reset mid-shift discards the partial shift count.
        step(1,0,0,0,0);
        step(0,1,0,0,1);
        step(0,1,0,0,1);
        step(0,1,0,0,1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ir",  s_ir,  5'h01);
        chk("midrst_tdo", s_tdo, 1'b1);
        chk("midrst_len", s_len, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0,1,0,0,1);
        step(0,1,0,0,0);
        step(0,0,1,0,0);
        chk("midrst_upd_s_ir",  s_ir,  5'h01);
        chk("midrst_upd_s_len", s_len, 1'b1);
        chk("midrst_upd_s_new", s_new, 1'b0);
        chk("midrst_upd_l_ir",  l_ir,  5'h1F);
        chk("midrst_upd_l_new", l_new, 1'b1);
        chk("midrst_upd_l_len", l_len, 1'b1);
        step(0,0,0,0,0);

        // 8-bit round trip of 8'hA5.
        pat = 8'hA5;
        step8(1,0,0,0);
        chk("w8_cap_tdo", tdo8, 1'b1);
        for (int b = 0; b < 8; b++) step8(0,1,0,pat[b]);
        step8(0,0,1,0);
        chk("w8_ir",  ir8,  8'hA5);
        chk("w8_new", new8, 1'b1);
        chk("w8_sub", sub8, 1'b0);
        chk("w8_len", len8, 1'b0);
        step8(0,0,0,0);
        chk("w8_new_drop", new8, 1'b0);
        // 7 shifts then update: rejected and flagged.
        step8(1,0,0,0);
        for (int b = 0; b < 7; b++) step8(0,1,0,1'b1);
        step8(0,0,1,0);
        chk("w8_short_ir",  ir8,  8'hA5);
        chk("w8_short_len", len8, 1'b1);
        chk("w8_short_new", new8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
